// File: rtl/stream_mux.sv
// stream_mux: CH-to-1 valid/ready stream multiplexer with a single registered output stage.
// Channel choice comes from an external select (MODE 0) or from round-robin arbitration (MODE 1).
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_data[CH*N]       channel k word at [k*N +: N]
//   in_valid/in_ready   per-channel handshake; in_ready is combinational and one-hot or zero
//   sel[SW]             channel select, MODE 0 only
//   out_data/out_valid  registered output word and valid
//   out_ready           downstream ready
//   grant[SW]           registered index of the channel whose word sits in out_data
module stream_mux #(
    parameter int N    = 32,
    parameter int CH   = 8,
    parameter int MODE = 0,
    localparam int SW  = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic [SW-1:0]   sel,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   grant
);
    logic [N-1:0]  words [CH];
    logic [SW-1:0] ptr, win, ch;
    logic [SW:0]   idx;
    logic          found, take, load_en, xfer;

    for (genvar k = 0; k < CH; k++) begin : g_words
        assign words[k] = in_data[k*N +: N];
    end

    // Round-robin search starting at ptr; the index wraps at CH, not at 2^SW.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < CH; i++) begin
            idx = {1'b0, ptr} + (SW+1)'(i);
            if (idx >= (SW+1)'(CH)) idx = idx - (SW+1)'(CH);
            if (!found && in_valid[idx[SW-1:0]]) begin
                found = 1'b1;
                win   = idx[SW-1:0];
            end
        end
    end

    // In MODE 0 the ready offer ignores in_valid so sel may change freely every cycle.
    assign load_en  = !out_valid || out_ready;
    assign take     = (MODE == 1) ? found : (int'(sel) < CH);
    assign ch       = (MODE == 1) ? win : sel;
    assign in_ready = (rst_n && load_en && take) ? CH'(1) << ch : '0;
    assign xfer     = |(in_ready & in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= words[ch];
                    grant    <= ch;
                end
            end
            if (MODE == 1 && xfer) ptr <= (win == SW'(CH-1)) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed checks of stream_mux in select and round-robin modes, 8 and 5 channels.
module tb_stream_mux;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic [255:0] d8;
    logic [159:0] d5;
    logic [7:0]  v0, v1, ir0, ir1;
    logic [4:0]  v2, v3, ir2, ir3;
    logic [2:0]  s0, s1, s2, s3, g0, g1, g2, g3;
    logic        r0, r1, r2, r3, ov0, ov1, ov2, ov3;
    logic [31:0] od0, od1, od2, od3;

    stream_mux #(.N(32), .CH(8), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .in_data(d8), .in_valid(v0),
        .in_ready(ir0), .sel(s0), .out_data(od0), .out_valid(ov0), .out_ready(r0), .grant(g0));
    stream_mux #(.N(32), .CH(8), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .in_data(d8), .in_valid(v1),
        .in_ready(ir1), .sel(s1), .out_data(od1), .out_valid(ov1), .out_ready(r1), .grant(g1));
    stream_mux #(.N(32), .CH(5), .MODE(1)) u2 (.clk(clk), .rst_n(rst_n), .in_data(d5), .in_valid(v2),
        .in_ready(ir2), .sel(s2), .out_data(od2), .out_valid(ov2), .out_ready(r2), .grant(g2));
    stream_mux #(.N(32), .CH(5), .MODE(0)) u3 (.clk(clk), .rst_n(rst_n), .in_data(d5), .in_valid(v3),
        .in_ready(ir3), .sel(s3), .out_data(od3), .out_valid(ov3), .out_ready(r3), .grant(g3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d8[k*32 +: 32] = 32'hA5A5_0000 | k;
        for (int k = 0; k < 5; k++) d5[k*32 +: 32] = 32'h5A5A_0000 | k;
        rst_n = 1'b0;
        v0 = 8'hFF; s0 = 3'd5; r0 = 1'b1;
        v1 = '0; s1 = '0; r1 = 1'b1;
        v2 = '0; s2 = '0; r2 = 1'b1;
        v3 = '0; s3 = '0; r3 = 1'b1;
        #12;
        chk("rst_ov", ov0, 0);
        chk("rst_od", od0, 0);
        chk("rst_g", g0, 0);
        chk("rst_ir", ir0, 0);
        rst_n = 1'b1;
        #1;
        chk("m0_ir_sel5", ir0, 8'h20);
        tick();
        chk("m0_od_sel5", od0, 32'hA5A5_0005);
        chk("m0_g_sel5", g0, 5);
        chk("m0_ov_sel5", ov0, 1);
        s0 = 3'd3; r0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("m0_stall_ir", ir0, 0);
            chk("m0_stall_od", od0, 32'hA5A5_0005);
            chk("m0_stall_ov", ov0, 1);
            tick();
        end
        r0 = 1'b1;
        #1;
        chk("m0_resume_ir", ir0, 8'h08);
        tick();
        chk("m0_resume_od", od0, 32'hA5A5_0003);
        chk("m0_resume_g", g0, 3);
        chk("m0_resume_ov", ov0, 1);
        v0 = 8'h00;
        #1;
        chk("m0_ir_novalid", ir0, 8'h08);
        tick();
        chk("m0_bubble_ov", ov0, 0);
        chk("m0_bubble_od", od0, 32'hA5A5_0003);
        chk("m0_bubble_g", g0, 3);

        v1 = 8'hFF;
        #1;
        chk("rr8_ir_first", ir1, 8'h01);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rr8_g", g1, i % 8);
            chk("rr8_ov", ov1, 1);
        end
        chk("rr8_od", od1, 32'hA5A5_0001);
        r1 = 1'b0;
        #1;
        chk("rr8_stall_ir", ir1, 0);
        tick();
        chk("rr8_stall_g", g1, 1);
        r1 = 1'b1; v1 = 8'b0000_0010;
        #1;
        chk("rr8_wrap_ir", ir1, 8'h02);
        tick();
        chk("rr8_wrap_g", g1, 1);
        v1 = 8'b1000_0100;
        #1;
        chk("rr8_next_ir", ir1, 8'h04);
        tick();
        chk("rr8_next_g", g1, 2);

        v2 = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr5_ir", ir2, (i % 2 == 0) ? 5'h01 : 5'h10);
            tick();
            chk("rr5_g", g2, (i % 2 == 0) ? 0 : 4);
            chk("rr5_od", od2, (i % 2 == 0) ? 32'h5A5A_0000 : 32'h5A5A_0004);
        end

        v3 = 5'h1F; s3 = 3'd6;
        #1;
        chk("m0c5_ir_sel6", ir3, 0);
        tick();
        chk("m0c5_ov_sel6", ov3, 0);
        s3 = 3'd4;
        #1;
        chk("m0c5_ir_sel4", ir3, 5'h10);
        tick();
        chk("m0c5_od_sel4", od3, 32'h5A5A_0004);
        chk("m0c5_g_sel4", g3, 4);

        v0 = 8'hFF; s0 = 3'd2; r0 = 1'b1;
        tick();
        r0 = 1'b0;
        chk("pre_rst_g", g0, 2);
        chk("pre_rst_ov", ov0, 1);
        v1 = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ov", ov0, 0);
        chk("async_rst_od", od0, 0);
        chk("async_rst_g", g0, 0);
        chk("async_rst_ir1", ir1, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ir0", ir0, 8'h04);
        chk("post_rst_ir1", ir1, 8'h01);
        tick();
        chk("post_rst_g1", g1, 0);
        chk("post_rst_ov1", ov1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
